// File: rtl/zstr_arb.sv
// zstr_arb: round-robin merge of N zstr input streams onto one registered
// zstr output that carries the source index of each word with the word.
//
// Ports:
//   z_clk, z_rst_n         clock (rising edge), synchronous active-low reset
//   zi_vld[N], zi_bus[N*BW] per-port valid and bus (port i at [i*BW +: BW])
//   zi_ack[N]              per-port acknowledge, at most one bit set
//   zo_vld, zo_bus, zo_src output valid, bus and source index
//   zo_ack                 output acknowledge
//
// Build option: define ZSTR_ARB_LOCK_EN to hold the grant on one port
// from a word with bus[LB]=0 up to and including the next word with
// bus[LB]=1 (packet lock).

module zstr_arb #(
    parameter int N  = 4,
    parameter int BW = 32,
    parameter int SW = 2,
    parameter int LB = 31
) (
    input  logic            z_clk,
    input  logic            z_rst_n,
    input  logic [N-1:0]    zi_vld,
    input  logic [N*BW-1:0] zi_bus,
    output logic [N-1:0]    zi_ack,
    output logic            zo_vld,
    output logic [BW-1:0]   zo_bus,
    output logic [SW-1:0]   zo_src,
    input  logic            zo_ack
);

    logic          zo_vld_q, zo_vld_d;
    logic [BW-1:0] zo_bus_q, zo_bus_d;
    logic [SW-1:0] zo_src_q, zo_src_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          oa;
    logic          sel_vld;
    logic [SW-1:0] win;
    logic [BW-1:0] sel_bus;
    logic          take;

`ifdef ZSTR_ARB_LOCK_EN
    logic          lock_q, lock_d;
    logic [SW-1:0] lidx_q, lidx_d;
`endif

    // Output register can take a new word when empty or being drained.
    assign oa = zo_ack | ~zo_vld_q;

    // Winner search starts one past the last served port and wraps.
    always_comb begin
        sel_vld = 1'b0;
        win     = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!sel_vld && zi_vld[i] &&
                    ((int'(ptr_q) + k) % N) == i) begin
                    sel_vld = 1'b1;
                    win     = SW'(i);
                end
            end
        end
`ifdef ZSTR_ARB_LOCK_EN
        // A packet in flight owns the output, even when its port idles.
        if (lock_q) begin
            sel_vld = 1'b0;
            win     = lidx_q;
            for (int i = 0; i < N; i++) begin
                if (lidx_q == SW'(i)) begin
                    sel_vld = zi_vld[i];
                end
            end
        end
`endif
    end

    always_comb begin
        sel_bus = '0;
        for (int i = 0; i < N; i++) begin
            if (win == SW'(i)) begin
                sel_bus = zi_bus[i*BW +: BW];
            end
        end
    end

    // Reset gates the grant so no source sees a transfer in a reset cycle.
    assign take = oa & sel_vld & z_rst_n;

    always_comb begin
        zi_ack = '0;
        for (int i = 0; i < N; i++) begin
            if (take && win == SW'(i)) begin
                zi_ack[i] = 1'b1;
            end
        end
    end

    always_comb begin
        zo_vld_d = zo_vld_q;
        zo_bus_d = zo_bus_q;
        zo_src_d = zo_src_q;
        ptr_d    = ptr_q;
        if (oa) begin
            zo_vld_d = sel_vld;
            zo_bus_d = sel_bus;
            zo_src_d = win;
        end
        if (take) begin
            ptr_d = win;
        end
    end

`ifdef ZSTR_ARB_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        lidx_d = lidx_q;
        if (take) begin
            if (!sel_bus[LB]) begin
                lock_d = 1'b1;
                lidx_d = win;
            end else begin
                lock_d = 1'b0;
            end
        end
    end
`else
    // Without packet lock the last-word marker has no meaning.
    logic lb_unused;
    assign lb_unused = sel_bus[LB];
`endif

    always_ff @(posedge z_clk) begin
        if (!z_rst_n) begin
            zo_vld_q <= 1'b0;
            zo_src_q <= '0;
            ptr_q    <= SW'(N-1);
`ifdef ZSTR_ARB_LOCK_EN
            lock_q   <= 1'b0;
            lidx_q   <= '0;
`endif
        end else begin
            zo_vld_q <= zo_vld_d;
            zo_src_q <= zo_src_d;
            ptr_q    <= ptr_d;
`ifdef ZSTR_ARB_LOCK_EN
            lock_q   <= lock_d;
            lidx_q   <= lidx_d;
`endif
        end
    end

    // Data path register carries no reset; zo_vld qualifies it.
    always_ff @(posedge z_clk) begin
        zo_bus_q <= zo_bus_d;
    end

    assign zo_vld = zo_vld_q;
    assign zo_bus = zo_bus_q;
    assign zo_src = zo_src_q;

endmodule

// File: tb/tb_zstr_arb.sv
// tb_zstr_arb: scoreboard bench for zstr_arb with a behavioural
// round-robin model; directed phases followed by randomized traffic.

module tb_zstr_arb;

    localparam int N  = 4;
    localparam int BW = 32;
    localparam int SW = 2;
    localparam int LB = 31;

    logic            z_clk = 1'b0;
    logic            z_rst_n;
    logic [N-1:0]    zi_vld;
    logic [N*BW-1:0] zi_bus;
    logic [N-1:0]    zi_ack;
    logic            zo_vld;
    logic [BW-1:0]   zo_bus;
    logic [SW-1:0]   zo_src;
    logic            zo_ack;

    zstr_arb #(.N(N), .BW(BW), .SW(SW), .LB(LB)) dut (
        .z_clk   (z_clk),
        .z_rst_n (z_rst_n),
        .zi_vld  (zi_vld),
        .zi_bus  (zi_bus),
        .zi_ack  (zi_ack),
        .zo_vld  (zo_vld),
        .zo_bus  (zo_bus),
        .zo_src  (zo_src),
        .zo_ack  (zo_ack)
    );

    always #5 z_clk = ~z_clk;

    typedef struct {
        logic [BW-1:0] data;
        int            gap;
    } word_t;

    typedef struct {
        logic [BW-1:0] data;
        int            src;
    } exp_t;

    word_t         src_q[N][$];
    exp_t          sb[$];
    bit            pres[N];
    int            gapc[N];
    logic [BW-1:0] cur[N];

    int m_ptr;
    bit m_lock;
    int m_lidx;
    bit m_ovld;

    int ack_mode;
    bit hold_arm;
    int hold_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(bit ok, string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: a word leaves whenever valid and ack are both high.
    always @(negedge z_clk) begin
        exp_t e;
        if (z_rst_n === 1'b1 && zo_vld === 1'b1 && zo_ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_out", 64'(zo_bus), 64'(0));
            end else begin
                e = sb.pop_front();
                chk(zo_src === SW'(e.src), "zo_src", 64'(zo_src), 64'(e.src));
                chk(zo_bus === e.data, "zo_bus", 64'(zo_bus), 64'(e.data));
            end
        end
    end

    task automatic add(int p, logic [BW-1:0] d, int g);
        word_t w;
        w.data = d;
        w.gap  = g;
        src_q[p].push_back(w);
    endtask

    function automatic bit idle();
        bit r;
        r = !m_ovld && sb.size() == 0;
        for (int p = 0; p < N; p++) begin
            if (pres[p] || src_q[p].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    // One clock: drive inputs, predict grant, then advance the model.
    task automatic cycle();
        bit           oa;
        int           win;
        logic [N-1:0] exp_ack;
        for (int p = 0; p < N; p++) begin
            if (!pres[p] && src_q[p].size() > 0) begin
                if (gapc[p] < src_q[p][0].gap) begin
                    gapc[p]++;
                end else begin
                    cur[p]  = src_q[p][0].data;
                    void'(src_q[p].pop_front());
                    pres[p] = 1'b1;
                    gapc[p] = 0;
                end
            end
            zi_vld[p] = pres[p];
            zi_bus[p*BW +: BW] = pres[p] ? cur[p] : BW'($urandom);
        end
        if (hold_arm && m_ovld) begin
            hold_cnt = 5;
            hold_arm = 1'b0;
        end
        if (hold_cnt > 0) begin
            zo_ack = 1'b0;
            hold_cnt--;
        end else begin
            zo_ack = (ack_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        end
        #1;
        oa  = zo_ack || !m_ovld;
        win = -1;
        if (m_lock) begin
            if (pres[m_lidx]) win = m_lidx;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && pres[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        exp_ack = '0;
        if (oa && win >= 0) exp_ack[win] = 1'b1;
        chk(zi_ack === exp_ack, "zi_ack", 64'(zi_ack), 64'(exp_ack));
        chk(zo_vld === m_ovld, "zo_vld", 64'(zo_vld), 64'(m_ovld));
        @(posedge z_clk);
        if (oa) m_ovld = (win >= 0);
        if (oa && win >= 0) begin
            sb.push_back('{data: cur[win], src: win});
            pres[win] = 1'b0;
            m_ptr     = win;
`ifdef ZSTR_ARB_LOCK_EN
            if (!cur[win][LB]) begin
                m_lock = 1'b1;
                m_lidx = win;
            end else begin
                m_lock = 1'b0;
            end
`endif
        end
        #2;
    endtask

    task automatic do_reset();
        z_rst_n = 1'b0;
        zo_ack  = 1'b0;
        zi_vld  = '1;
        for (int p = 0; p < N; p++) zi_bus[p*BW +: BW] = BW'($urandom);
        repeat (2) begin
            #1;
            chk(zi_ack === '0, "rst_zi_ack", 64'(zi_ack), 64'(0));
            @(posedge z_clk);
            #2;
            chk(zo_vld === 1'b0, "rst_zo_vld", 64'(zo_vld), 64'(0));
        end
        z_rst_n  = 1'b1;
        m_ptr    = N - 1;
        m_lock   = 1'b0;
        m_lidx   = 0;
        m_ovld   = 1'b0;
        hold_arm = 1'b0;
        hold_cnt = 0;
        sb.delete();
        for (int p = 0; p < N; p++) begin
            pres[p] = 1'b0;
            gapc[p] = 0;
        end
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (n < budget && !idle()) begin
            cycle();
            n++;
        end
        chk(idle(), "drain_timeout", 64'(n), 64'(budget));
    endtask

    initial begin
        int cnt;
        logic [BW-1:0] d;
        z_rst_n  = 1'b0;
        zi_vld   = '0;
        zi_bus   = '0;
        zo_ack   = 1'b0;
        ack_mode = 0;
        hold_arm = 1'b0;
        hold_cnt = 0;
        @(posedge z_clk);
        #2;

        // All ports busy, full throughput, distinct data per port.
        do_reset();
        for (int p = 0; p < N; p++) begin
            for (int w = 0; w < 8; w++) add(p, 32'h8000_0000 | (p << 24) | w, 0);
        end
        drain(200);

        // Lone requester on port 2.
        do_reset();
        for (int w = 0; w < 8; w++) add(2, 32'h8200_0000 | (w * 17), 0);
        drain(100);

        // Output stalled for 5 cycles once the first word is out.
        do_reset();
        for (int p = 0; p < N; p++) begin
            for (int w = 0; w < 3; w++) add(p, 32'h8000_1000 | (p << 24) | w, 0);
        end
        hold_arm = 1'b1;
        drain(200);

        // Three-word packet on port 1 with a gap, port 0 competing.
        do_reset();
        add(1, 32'h0100_0000, 0);
        add(1, 32'h0100_0001, 0);
        add(1, 32'h8100_0002, 1);
        for (int w = 0; w < 4; w++) add(0, 32'h8000_2000 | w, 0);
        drain(100);

        // Random traffic with random backpressure and a reset mid-stream.
        ack_mode = 1;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < N; p++) begin
                cnt = int'($urandom_range(20, 5));
                for (int w = 0; w < cnt; w++) begin
                    d = $urandom;
                    if (w == cnt - 1) d[LB] = 1'b1;
                    add(p, d, int'($urandom_range(2)));
                end
            end
            if (r == 1) begin
                repeat (40) cycle();
                do_reset();
            end
            drain(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
